// File: rtl/e203_exu_oitf_ctrl.sv
// Outstanding-instruction tracking FIFO: allocates an itag per dispatched
// long-pipe instruction, retires in order, and flags RAW/WAW hazards at dispatch.
module e203_exu_oitf_ctrl #(
    parameter int OITF_DEPTH = 4,
    parameter int ITAG_W     = 2,
    parameter int RFIDX_W    = 5,
    parameter int PC_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dis_ena,
    input  logic               disp_i_rdwen,
    input  logic [RFIDX_W-1:0] disp_i_rdidx,
    input  logic [PC_W-1:0]    disp_i_pc,
    input  logic               disp_i_rs1en,
    input  logic               disp_i_rs2en,
    input  logic [RFIDX_W-1:0] disp_i_rs1idx,
    input  logic [RFIDX_W-1:0] disp_i_rs2idx,
    input  logic               ret_ena,
    output logic               dis_ready,
    output logic [ITAG_W-1:0]  dis_ptr,
    output logic [ITAG_W-1:0]  ret_ptr,
    output logic [RFIDX_W-1:0] ret_rdidx,
    output logic               ret_rdwen,
    output logic [PC_W-1:0]    ret_pc,
    output logic               oitf_empty,
    output logic               oitf_full,
    output logic [ITAG_W:0]    oitf_cnt,
    output logic               oitfrd_match_disprs1,
    output logic               oitfrd_match_disprs2,
    output logic               oitfrd_match_disprd
);

    // Top bit of each pointer is the wrap flag; depth is a power of two so a
    // plain increment wraps the index and toggles the flag together.
    logic [ITAG_W:0]        alc_q;
    logic [ITAG_W:0]        ret_q;
    logic [OITF_DEPTH-1:0]  vld_q;
    logic                   rdwen_q [OITF_DEPTH];
    logic [RFIDX_W-1:0]     rdidx_q [OITF_DEPTH];
    logic [PC_W-1:0]        pc_q    [OITF_DEPTH];

    logic                   alc_fire;
    logic                   ret_fire;
    logic [ITAG_W-1:0]      alc_idx;
    logic [ITAG_W-1:0]      ret_idx;

    assign alc_idx    = alc_q[ITAG_W-1:0];
    assign ret_idx    = ret_q[ITAG_W-1:0];
    assign oitf_empty = (alc_idx == ret_idx) && (alc_q[ITAG_W] == ret_q[ITAG_W]);
    assign oitf_full  = (alc_idx == ret_idx) && (alc_q[ITAG_W] != ret_q[ITAG_W]);
    assign oitf_cnt   = alc_q - ret_q;
    assign dis_ready  = ~oitf_full;
    assign dis_ptr    = alc_idx;
    assign ret_ptr    = ret_idx;

    assign alc_fire   = dis_ena & ~oitf_full;
    assign ret_fire   = ret_ena & ~oitf_empty;

    assign ret_rdidx  = rdidx_q[ret_idx];
    assign ret_rdwen  = rdwen_q[ret_idx];
    assign ret_pc     = pc_q[ret_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_q <= '0;
            ret_q <= '0;
            vld_q <= '0;
        end else begin
            // Allocate and retire never target the same slot: that would need
            // the FIFO to be both full and empty.
            if (alc_fire) begin
                alc_q          <= alc_q + 1'b1;
                vld_q[alc_idx] <= 1'b1;
            end
            if (ret_fire) begin
                ret_q          <= ret_q + 1'b1;
                vld_q[ret_idx] <= 1'b0;
            end
        end
    end

    // Payload is qualified by the valid bits, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (alc_fire) begin
            rdwen_q[alc_idx] <= disp_i_rdwen;
            rdidx_q[alc_idx] <= disp_i_rdidx;
            pc_q[alc_idx]    <= disp_i_pc;
        end
    end

    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (vld_q[i] && rdwen_q[i]) begin
                if (disp_i_rs1en && (rdidx_q[i] == disp_i_rs1idx)) oitfrd_match_disprs1 = 1'b1;
                if (disp_i_rs2en && (rdidx_q[i] == disp_i_rs2idx)) oitfrd_match_disprs2 = 1'b1;
                if (disp_i_rdwen && (rdidx_q[i] == disp_i_rdidx))  oitfrd_match_disprd  = 1'b1;
            end
        end
    end

endmodule

// File: doc/e203_exu_oitf_ctrl.md
E203_EXU_OITF_CTRL -- requirements
Module: e203_exu_oitf_ctrl

Interface
REQ-001 Parameter OITF_DEPTH, default 4, number of outstanding-instruction entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter ITAG_W, default 2, itag width; SHALL equal log2(OITF_DEPTH).
REQ-003 Parameter RFIDX_W, default 5, register index width.
REQ-004 Parameter PC_W, default 32, PC width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 dis_ena  in  1  allocate one entry for a dispatched long-pipe/ALU-tracked instruction.
REQ-008 disp_i_rdwen  in  1  dispatched instruction writes rd.
REQ-009 disp_i_rdidx  in  RFIDX_W  dispatched rd index.
REQ-010 disp_i_pc  in  PC_W  dispatched PC.
REQ-011 disp_i_rs1en / disp_i_rs2en  in  1 each  source operand enables for hazard check.
REQ-012 disp_i_rs1idx / disp_i_rs2idx  in  RFIDX_W each  source indices for hazard check.
REQ-013 ret_ena  in  1  retire the head entry (driven by writeback: valid & ready & ~csr).
REQ-014 dis_ready  out  1  equals ~oitf_full.
REQ-015 dis_ptr  out  ITAG_W  itag assigned to the instruction dispatched this cycle.
REQ-016 ret_ptr  out  ITAG_W  itag of the head (oldest) entry.
REQ-017 ret_rdidx / ret_rdwen / ret_pc  out  RFIDX_W / 1 / PC_W  head entry payload.
REQ-018 oitf_empty / oitf_full  out  1 each  occupancy status.
REQ-019 oitf_cnt  out  ITAG_W+1  number of valid entries, 0..OITF_DEPTH.
REQ-020 oitfrd_match_disprs1 / _disprs2 / _disprd  out  1 each  RAW/RAW/WAW hazard flags.

Function
REQ-021 Pointers SHALL be ITAG_W index plus one wrap-flag bit each (alc and ret); index wraps OITF_DEPTH-1 -> 0 toggling its flag.
REQ-022 Empty SHALL be index equal and flags equal; full SHALL be index equal and flags different.
REQ-023 Allocation accepted iff dis_ena & ~oitf_full (current-cycle registered state); on accept, entry[alc index] written with valid=1, rdwen, rdidx, pc, and alc pointer advances next edge.
REQ-024 dis_ptr SHALL be the current alc index combinationally; the accepted instruction owns that itag.
REQ-025 Retirement accepted iff ret_ena & ~oitf_empty; head entry valid cleared and ret pointer advances next edge.
REQ-026 dis_ena while full SHALL be ignored: no write, no pointer move, dis_ready stays 0.
REQ-027 ret_ena while empty SHALL be ignored: no state change.
REQ-028 Simultaneous accepted allocate and retire SHALL both take effect; oitf_cnt unchanged; when full only retire is accepted, when empty only allocate.
REQ-029 oitf_cnt, empty, full SHALL update one cycle after an accepted event (registered state, no bypass).
REQ-030 ret_rdidx/ret_rdwen/ret_pc SHALL be read combinationally from entry[ret index]; value undefined-but-stable (last written) when empty.
REQ-031 oitfrd_match_disprs1 SHALL be 1 iff disp_i_rs1en and some entry has valid & rdwen & rdidx==disp_i_rs1idx; rs2 likewise with rs2en/rs2idx.
REQ-032 oitfrd_match_disprd SHALL be 1 iff disp_i_rdwen and some valid & rdwen entry has rdidx==disp_i_rdidx.
REQ-033 Match logic SHALL be purely combinational over registered entries; an entry allocated this cycle does not match until the next cycle; an entry retired this cycle still matches this cycle.
REQ-034 Index value 0 SHALL be compared like any other index (no x0 exclusion here).

Reset
REQ-035 On rst_n low, asynchronously: both pointers and flags 0, all valid bits 0, so oitf_empty=1, oitf_full=0, dis_ready=1, oitf_cnt=0, dis_ptr=0, ret_ptr=0, all match flags 0.
REQ-036 Reset mid-operation SHALL discard all outstanding entries; payload storage need not be cleared.

Verification
REQ-037 Reset, then dis_ena one cycle with rdwen=1 rdidx=5 pc=0x80 -> dis_ptr=0 that cycle; next cycle empty=0, cnt=1, ret_ptr=0, ret_rdidx=5, ret_pc=0x80.
REQ-038 Four back-to-back allocations, depth 4 -> dis_ptr 0,1,2,3; then full=1, dis_ready=0, cnt=4; fifth dis_ena ignored, cnt stays 4.
REQ-039 From full, ret_ena and dis_ena same cycle -> only retire accepted; cnt=3, ret_ptr=1, full=0; next dis_ena gets dis_ptr=0 (wrap) and cnt=4.
REQ-040 With entries rdidx 3 and 7 valid, rs1idx=7 rs1en=1, rs2idx=3 rs2en=0, rdidx=3 rdwen=1 -> match_rs1=1, match_rs2=0, match_rd=1; after both retire -> all 0.
REQ-041 ret_ena on empty FIFO -> no change, cnt=0, ret_ptr=0; assert rst_n low with cnt=2 -> immediately empty=1, cnt=0.
